// File: rtl/affine_engine.sv
// affine_engine: parametrised affine-layer compute engine.
// On start it reads DEPTH banks of N_CH input words and N_CH signed weights,
// forms bias + sum(x*w) for each of N_OUT outputs, and writes each result,
// with optional ReLU and saturation, to an output memory.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start, relu       run request (sampled in IDLE) and ReLU enable (latched at start)
//   busy              high while a run is in progress
//   imem_bank/imem_rd common bank address and read strobe for the input memories
//   imem_in           N_CH packed signed input words, valid 1 cycle after imem_rd
//   wmem_addr/wmem_rd weight address {out_idx, bank} and read strobe
//   wmem_in           N_CH packed signed weights, valid 1 cycle after wmem_rd
//   bias_in           signed bias for the output selected by bias_idx
//   bias_idx          index of the output currently accumulating
//   omem_addr/omem_wr/omem_out  result write port
module affine_engine #(
  parameter int unsigned N_CH  = 5,
  parameter int unsigned DW    = 6,
  parameter int unsigned WW    = 6,
  parameter int unsigned AW    = 6,
  parameter int unsigned ACCW  = 14,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned OAW   = 2,
  parameter int unsigned SAT   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   relu,
  output logic                   busy,
  output logic [AW-1:0]          imem_bank,
  output logic                   imem_rd,
  input  logic [N_CH*DW-1:0]     imem_in,
  output logic [OAW+AW-1:0]      wmem_addr,
  output logic                   wmem_rd,
  input  logic [N_CH*WW-1:0]     wmem_in,
  input  logic [ACCW-1:0]        bias_in,
  output logic [OAW-1:0]         bias_idx,
  output logic [OAW-1:0]         omem_addr,
  output logic                   omem_wr,
  output logic [ACCW-1:0]        omem_out
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = DW + WW;
  localparam int unsigned ACC_W = DW + WW + AW + $clog2(N_CH) + 1;
  localparam int          SAT_MAX_I = (1 << (ACCW - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_I - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_DRAIN1 = 3'd2;
  localparam logic [2:0] S_DRAIN2 = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  logic [2:0]              state, state_nx;
  logic [AW-1:0]           bank, bank_nx;
  logic [OAW-1:0]          out_idx, out_idx_nx;
  logic                    relu_q, relu_nx;

  // Pipeline: rd_q marks memory data valid, prod_v marks registered operands valid.
  logic                    rd_q;
  logic                    prod_v;
  logic [N_CH*DW-1:0]      x_q;
  logic [N_CH*WW-1:0]      w_q;
  logic signed [ACC_W-1:0] acc;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] dot;
  logic signed [ACC_W-1:0] acc_fin;
  logic signed [ACC_W-1:0] res_full;
  logic [ACCW-1:0]         result;

  // Next-state logic
  always_comb begin
    state_nx   = state;
    bank_nx    = bank;
    out_idx_nx = out_idx;
    relu_nx    = relu_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx   = S_ISSUE;
          bank_nx    = '0;
          out_idx_nx = '0;
          relu_nx    = relu;
        end
      end
      S_ISSUE: begin
        bank_nx = bank + AW'(1);
        if (bank == AW'(DEPTH - 1)) begin
          state_nx = S_DRAIN1;
        end
      end
      S_DRAIN1: state_nx = S_DRAIN2;
      S_DRAIN2: state_nx = S_WRITE;
      S_WRITE: begin
        if (out_idx == OAW'(N_OUT - 1)) begin
          state_nx = S_IDLE;
        end else begin
          state_nx   = S_ISSUE;
          out_idx_nx = out_idx + OAW'(1);
          bank_nx    = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Dot product of the registered operand bank
  always_comb begin
    prod = '0;
    dot  = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      prod = PW'($signed(x_q[c*DW +: DW])) * PW'($signed(w_q[c*WW +: WW]));
      dot  = dot + ACC_W'(prod);
    end
  end

  // The last product is folded in here so the result can be registered
  // on the same edge that enters WRITE.
  always_comb begin
    acc_fin = prod_v ? acc + dot : acc;
  end

  // ReLU then saturate or wrap to the output width
  always_comb begin
    res_full = acc_fin;
    if (relu_q && (acc_fin < 0)) begin
      res_full = '0;
    end
    if (SAT != 0) begin
      if (res_full > SAT_MAX) begin
        res_full = SAT_MAX;
      end else if (res_full < SAT_MIN) begin
        res_full = SAT_MIN;
      end
    end
    result = res_full[ACCW-1:0];
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      bank      <= '0;
      out_idx   <= '0;
      relu_q    <= 1'b0;
      rd_q      <= 1'b0;
      prod_v    <= 1'b0;
      x_q       <= '0;
      w_q       <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      imem_rd   <= 1'b0;
      wmem_rd   <= 1'b0;
      imem_bank <= '0;
      wmem_addr <= '0;
      bias_idx  <= '0;
      omem_wr   <= 1'b0;
      omem_addr <= '0;
      omem_out  <= '0;
    end else begin
      state   <= state_nx;
      bank    <= bank_nx;
      out_idx <= out_idx_nx;
      relu_q  <= relu_nx;

      busy      <= (state_nx != S_IDLE);
      imem_rd   <= (state_nx == S_ISSUE);
      wmem_rd   <= (state_nx == S_ISSUE);
      imem_bank <= bank_nx;
      wmem_addr <= {out_idx_nx, bank_nx};
      bias_idx  <= out_idx_nx;

      omem_wr <= (state_nx == S_WRITE);
      if (state_nx == S_WRITE) begin
        omem_addr <= out_idx_nx;
        omem_out  <= result;
      end

      rd_q   <= imem_rd;
      prod_v <= rd_q;
      if (rd_q) begin
        x_q <= imem_in;
        w_q <= wmem_in;
      end

      // Bias is loaded during the first issue cycle, once bias_idx already
      // points at the new output; no products are in flight at that point.
      if ((state == S_ISSUE) && (bank == '0)) begin
        acc <= ACC_W'($signed(bias_in));
      end else if (prod_v) begin
        acc <= acc_fin;
      end
    end
  end

endmodule

// File: tb/tb_affine_engine.sv
// Testbench for affine_engine: two instances (saturating and wrapping) share
// stimulus; behavioural memories feed them and a scoreboard checks every write.
module tb_affine_engine;

  localparam int N_CH  = 5;
  localparam int DW    = 6;
  localparam int WW    = 6;
  localparam int AW    = 6;
  localparam int ACCW  = 14;
  localparam int N_OUT = 4;
  localparam int OAW   = 2;
  localparam int DEPTH = 64;

  typedef struct {
    int x;
    int w0;
    int wstep;
    int bias0;
    int bstep;
    bit relu;
    bit vary;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic relu  = 1'b0;

  logic                a_busy, b_busy;
  logic [AW-1:0]       a_imem_bank, b_imem_bank;
  logic                a_imem_rd, b_imem_rd;
  logic [N_CH*DW-1:0]  a_imem_in, b_imem_in;
  logic [OAW+AW-1:0]   a_wmem_addr, b_wmem_addr;
  logic                a_wmem_rd, b_wmem_rd;
  logic [N_CH*WW-1:0]  a_wmem_in, b_wmem_in;
  logic [ACCW-1:0]     a_bias_in, b_bias_in;
  logic [OAW-1:0]      a_bias_idx, b_bias_idx;
  logic [OAW-1:0]      a_omem_addr, b_omem_addr;
  logic                a_omem_wr, b_omem_wr;
  logic [ACCW-1:0]     a_omem_out, b_omem_out;

  vec_t cur = '{x: 0, w0: 0, wstep: 0, bias0: 0, bstep: 0, relu: 1'b0, vary: 1'b0};
  vec_t vecs [7];

  logic [OAW+ACCW-1:0] q_a [$];
  logic [OAW+ACCW-1:0] q_b [$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  affine_engine #(.SAT(1)) dut (
    .clock(clock), .reset(reset), .start(start), .relu(relu), .busy(a_busy),
    .imem_bank(a_imem_bank), .imem_rd(a_imem_rd), .imem_in(a_imem_in),
    .wmem_addr(a_wmem_addr), .wmem_rd(a_wmem_rd), .wmem_in(a_wmem_in),
    .bias_in(a_bias_in), .bias_idx(a_bias_idx),
    .omem_addr(a_omem_addr), .omem_wr(a_omem_wr), .omem_out(a_omem_out)
  );

  affine_engine #(.SAT(0)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .relu(relu), .busy(b_busy),
    .imem_bank(b_imem_bank), .imem_rd(b_imem_rd), .imem_in(b_imem_in),
    .wmem_addr(b_wmem_addr), .wmem_rd(b_wmem_rd), .wmem_in(b_wmem_in),
    .bias_in(b_bias_in), .bias_idx(b_bias_idx),
    .omem_addr(b_omem_addr), .omem_wr(b_omem_wr), .omem_out(b_omem_out)
  );

  // Stimulus data as a function of channel, bank and output index
  function automatic int x_of(int c, int b);
    return cur.x + (cur.vary ? ((b + c) % 5) - 2 : 0);
  endfunction

  function automatic int w_of(int o, int c, int b);
    return cur.w0 + cur.wstep * o + (cur.vary ? ((3 * b + c) % 4) - 1 : 0);
  endfunction

  function automatic int bias_of(int o);
    return cur.bias0 + cur.bstep * o;
  endfunction

  function automatic logic [N_CH*DW-1:0] pack_x(int b);
    logic [N_CH*DW-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) v[c*DW +: DW] = DW'(x_of(c, b));
    return v;
  endfunction

  function automatic logic [N_CH*WW-1:0] pack_w(logic [OAW+AW-1:0] a);
    logic [N_CH*WW-1:0] v;
    int o;
    int b;
    o = int'(a[OAW+AW-1:AW]);
    b = int'(a[AW-1:0]);
    v = '0;
    for (int c = 0; c < N_CH; c++) v[c*WW +: WW] = WW'(w_of(o, c, b));
    return v;
  endfunction

  // Reference result for one output
  function automatic logic [ACCW-1:0] model(int o, bit sat);
    longint acc;
    acc = longint'(bias_of(o));
    for (int b = 0; b < DEPTH; b++)
      for (int c = 0; c < N_CH; c++)
        acc += longint'(x_of(c, b) * w_of(o, c, b));
    if (cur.relu && acc < 0) acc = 0;
    if (sat) begin
      if (acc > 8191) acc = 8191;
      else if (acc < -8192) acc = -8192;
    end
    return ACCW'(acc);
  endfunction

  // Synchronous memories, one per instance
  always @(posedge clock) begin
    if (a_imem_rd) a_imem_in <= pack_x(int'(a_imem_bank));
    if (a_wmem_rd) a_wmem_in <= pack_w(a_wmem_addr);
    if (b_imem_rd) b_imem_in <= pack_x(int'(b_imem_bank));
    if (b_wmem_rd) b_wmem_in <= pack_w(b_wmem_addr);
  end

  assign a_bias_in = ACCW'(cur.bias0 + cur.bstep * int'(a_bias_idx));
  assign b_bias_in = ACCW'(cur.bias0 + cur.bstep * int'(b_bias_idx));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_outputs(input int n);
    for (int o = 0; o < n; o++) begin
      q_a.push_back({OAW'(o), model(o, 1'b1)});
      q_b.push_back({OAW'(o), model(o, 1'b0)});
    end
  endtask

  // Scoreboard: every write must match the oldest expected entry
  always @(negedge clock) begin
    if (a_omem_wr === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write_sat: addr=%0d data=%0d, expected no write", a_omem_addr, a_omem_out);
      end else begin
        check("write_sat {addr,data}", 32'({a_omem_addr, a_omem_out}), 32'(q_a.pop_front()));
      end
    end
    if (b_omem_wr === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write_wrap: addr=%0d data=%0d, expected no write", b_omem_addr, b_omem_out);
      end else begin
        check("write_wrap {addr,data}", 32'({b_omem_addr, b_omem_out}), 32'(q_b.pop_front()));
      end
    end
  end

  // One complete run with latency and busy-length checks
  task automatic run_full(input vec_t v, input int idx);
    int first;
    int busy_cnt;
    int n;
    cur  = v;
    relu = v.relu;
    push_outputs(N_OUT);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    first = 0;
    busy_cnt = 0;
    n = 1;
    while (n < 1000) begin
      if (a_busy === 1'b1) busy_cnt++;
      if (a_omem_wr === 1'b1 && first == 0) first = n;
      if (a_busy !== 1'b1) break;
      @(negedge clock);
      n++;
    end
    check($sformatf("vec%0d first_write_cycle", idx), 32'(first), 32'd67);
    check($sformatf("vec%0d busy_cycles", idx), 32'(busy_cnt), 32'd268);
    check($sformatf("vec%0d sat_queue_left", idx), 32'(q_a.size()), 32'd0);
    check($sformatf("vec%0d wrap_queue_left", idx), 32'(q_b.size()), 32'd0);
    check($sformatf("vec%0d strobes_idle", idx), {30'd0, a_imem_rd, a_wmem_rd}, 32'd0);
  endtask

  initial begin
    int n;
    int fall1;
    int fall2;

    vecs[0] = '{x:  1, w0:  1, wstep: 0, bias0:     0, bstep:   0, relu: 1'b0, vary: 1'b0};
    vecs[1] = '{x: 31, w0: 31, wstep: 0, bias0:     0, bstep:   0, relu: 1'b0, vary: 1'b0};
    vecs[2] = '{x: -1, w0:  1, wstep: 0, bias0:    10, bstep:   0, relu: 1'b1, vary: 1'b0};
    vecs[3] = '{x: -1, w0:  1, wstep: 0, bias0:    10, bstep:   0, relu: 1'b0, vary: 1'b0};
    vecs[4] = '{x:  1, w0:  1, wstep: 1, bias0:     0, bstep: 100, relu: 1'b0, vary: 1'b0};
    vecs[5] = '{x:-32, w0: 31, wstep: 0, bias0: -8000, bstep:   0, relu: 1'b0, vary: 1'b0};
    vecs[6] = '{x:  0, w0:  2, wstep:-1, bias0:   -50, bstep:  37, relu: 1'b0, vary: 1'b1};

    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset busy", {31'd0, a_busy}, 32'd0);
    check("reset read strobes", {30'd0, a_imem_rd, a_wmem_rd}, 32'd0);
    check("reset omem_wr", {31'd0, a_omem_wr}, 32'd0);
    check("reset omem_out", 32'(a_omem_out), 32'd0);
    check("reset addresses", 32'({a_imem_bank, a_wmem_addr, a_omem_addr, a_bias_idx}), 32'd0);
    check("reset wrap busy/out", 32'({b_busy, b_omem_out}), 32'd0);
    reset = 1'b0;

    // Table-driven runs
    for (int i = 0; i < 7; i++) run_full(vecs[i], i);

    // Reset during output 1, bank 20
    cur  = vecs[0];
    relu = 1'b0;
    push_outputs(1);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (n < 500 && !(a_bias_idx === 2'd1 && a_imem_bank === 6'd20)) begin
      @(negedge clock);
      n++;
    end
    check("abort point wmem_addr", 32'(a_wmem_addr), 32'({2'd1, 6'd20}));
    check("abort point imem_rd", {31'd0, a_imem_rd}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort busy", {30'd0, a_busy, b_busy}, 32'd0);
    check("abort read strobes", {30'd0, a_imem_rd, a_wmem_rd}, 32'd0);
    check("abort omem_out", 32'(a_omem_out), 32'd0);
    check("abort imem_bank", 32'(a_imem_bank), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("abort queues drained", 32'(q_a.size() + q_b.size()), 32'd0);
    run_full(vecs[0], 10);

    // Back-to-back: ignored mid-run pulse, start held across completion
    cur  = vecs[4];
    relu = 1'b0;
    push_outputs(N_OUT);
    push_outputs(N_OUT);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    fall1 = 0;
    fall2 = 0;
    while (n < 1200 && fall2 == 0) begin
      if (n == 100) start = 1'b1;
      if (n == 101) start = 1'b0;
      if (n == 250) start = 1'b1;
      if (fall1 == 0) begin
        if (a_busy !== 1'b1) fall1 = n;
      end else if (n == fall1 + 1) begin
        check("b2b busy rises after one idle cycle", {31'd0, a_busy}, 32'd1);
        start = 1'b0;
      end else if (a_busy !== 1'b1) begin
        fall2 = n;
      end
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    check("b2b first run end", 32'(fall1), 32'd269);
    check("b2b second run end", 32'(fall2), 32'd538);
    check("b2b queues drained", 32'(q_a.size() + q_b.size()), 32'd0);

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
